// File: rtl/pc_ctrl_pkg.sv
// Shared constants for the PC/flag control unit:
// condition codes and flag bit positions.
package pc_ctrl_pkg;

  localparam logic [2:0] COND_NE     = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_GT     = 3'b010;
  localparam logic [2:0] COND_LT     = 3'b011;
  localparam logic [2:0] COND_GE     = 3'b100;
  localparam logic [2:0] COND_LE     = 3'b101;
  localparam logic [2:0] COND_OV     = 3'b110;
  localparam logic [2:0] COND_UNCOND = 3'b111;

  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition evaluator: maps a 3-bit condition
// code and the effective N/Z/V flags to cond_true.
module branch_cond_eval
  import pc_ctrl_pkg::*;
(
  input  logic [2:0] i_cond,
  input  logic       i_n,
  input  logic       i_z,
  input  logic       i_v,
  output logic       o_true
);

  always_comb begin
    o_true = 1'b0;
    unique case (i_cond)
      COND_NE:     o_true = !i_z;
      COND_EQ:     o_true = i_z;
      COND_GT:     o_true = !i_z && !i_n;
      COND_LT:     o_true = i_n;
      COND_GE:     o_true = i_z || !i_n;
      COND_LE:     o_true = i_n || i_z;
      COND_OV:     o_true = i_v;
      COND_UNCOND: o_true = 1'b1;
      default:     o_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter unit: PC and N/Z/V flag state, branch
// resolution, stall and sticky halt.
module pc_seq_unit
  import pc_ctrl_pkg::*;
#(
  parameter int          ADDR_W      = 16,
  parameter int          IMM_W       = 9,
  parameter int          PC_STEP     = 2,
  parameter int          IMM_SHIFT   = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter bit          FLAG_BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              halt,
  input  logic              br_en,
  input  logic              br_reg_mode,
  input  logic [2:0]        cond,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] br_reg,
  input  logic [2:0]        flag_we,
  input  logic [2:0]        flag_in,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus,
  output logic              taken,
  output logic [2:0]        flags,
  output logic              halted
);

  logic [ADDR_W-1:0] r_pc;
  logic [2:0]        r_flags;
  logic              r_halted;

  logic [ADDR_W-1:0] w_pc_plus;
  logic [ADDR_W-1:0] w_imm_sx;
  logic [ADDR_W-1:0] w_imm_off;
  logic [ADDR_W-1:0] w_target;
  logic [2:0]        w_flags_wr;
  logic [2:0]        w_flags_eff;
  logic              w_cond_true;
  logic              w_taken;

  logic [ADDR_W-1:0] w_pc_nxt;
  logic [2:0]        w_flags_nxt;
  logic              w_halted_nxt;

  assign w_pc_plus = r_pc + ADDR_W'(PC_STEP);
  assign w_imm_sx  = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign w_imm_off = w_imm_sx << IMM_SHIFT;
  assign w_target  = br_reg_mode ? br_reg
                                 : w_pc_plus + w_imm_off;

  assign w_flags_wr  = (flag_we & flag_in) | (~flag_we & r_flags);
  assign w_flags_eff = FLAG_BYPASS ? w_flags_wr : r_flags;

  branch_cond_eval u_cond (
    .i_cond (cond),
    .i_n    (w_flags_eff[FLAG_N]),
    .i_z    (w_flags_eff[FLAG_Z]),
    .i_v    (w_flags_eff[FLAG_V]),
    .o_true (w_cond_true)
  );

  assign w_taken = br_en && w_cond_true && !stall
                && !r_halted && !halt;

  always_comb begin
    w_pc_nxt     = r_pc;
    w_flags_nxt  = r_flags;
    w_halted_nxt = r_halted;
    if (!r_halted && !stall) begin
      w_flags_nxt = w_flags_wr;
      if (halt)         w_halted_nxt = 1'b1;
      else if (w_taken) w_pc_nxt     = w_target;
      else              w_pc_nxt     = w_pc_plus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_flags  <= 3'b000;
      r_halted <= 1'b0;
    end else begin
      r_pc     <= w_pc_nxt;
      r_flags  <= w_flags_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  assign pc      = r_pc;
  assign pc_plus = w_pc_plus;
  assign taken   = w_taken;
  assign flags   = r_flags;
  assign halted  = r_halted;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: reference model feeds a queue of
// expected state, compared one cycle after each drive.
module tb_pc_seq_unit;

  logic        clk = 1'b0;
  logic        rst, stall, halt, br_en, br_reg_mode;
  logic [2:0]  cond, flag_we, flag_in;
  logic [8:0]  imm;
  logic [15:0] br_reg;

  logic [15:0] pc, pc_plus, nb_pc, nb_pc_plus;
  logic        taken, halted, nb_taken, nb_halted;
  logic [2:0]  flags, nb_flags;

  typedef struct packed {
    logic [15:0] pc;
    logic [2:0]  flags;
    logic        halted;
  } st_t;

  st_t q_exp[$];
  st_t m;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pc_seq_unit #(.FLAG_BYPASS(1'b1)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt),
    .br_en(br_en), .br_reg_mode(br_reg_mode),
    .cond(cond), .imm(imm), .br_reg(br_reg),
    .flag_we(flag_we), .flag_in(flag_in),
    .pc(pc), .pc_plus(pc_plus), .taken(taken),
    .flags(flags), .halted(halted)
  );

  pc_seq_unit #(.FLAG_BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt),
    .br_en(br_en), .br_reg_mode(br_reg_mode),
    .cond(cond), .imm(imm), .br_reg(br_reg),
    .flag_we(flag_we), .flag_in(flag_in),
    .pc(nb_pc), .pc_plus(nb_pc_plus), .taken(nb_taken),
    .flags(nb_flags), .halted(nb_halted)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  function automatic logic cond_ok(input logic [2:0] c,
                                   input logic [2:0] f);
    logic n, z, v;
    n = f[0]; z = f[1]; v = f[2];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  // Drive one cycle's inputs, check the combinational
  // outputs and queue the state expected after the edge.
  task automatic drive(input logic rs, st, hl, be, brm,
                       input logic [2:0] cd,
                       input logic [8:0] im,
                       input logic [15:0] br,
                       input logic [2:0] fwe, fin);
    logic [2:0]  f_new;
    logic [15:0] pcp, tgt;
    logic        tk;
    st_t         nx;
    rst = rs; stall = st; halt = hl; br_en = be;
    br_reg_mode = brm; cond = cd; imm = im;
    br_reg = br; flag_we = fwe; flag_in = fin;
    #1;
    f_new = m.flags;
    for (int i = 0; i < 3; i++)
      if (fwe[i]) f_new[i] = fin[i];
    pcp = m.pc + 16'd2;
    tgt = brm ? br
              : pcp + ({{7{im[8]}}, im} << 1);
    tk  = be && cond_ok(cd, f_new) && !st
       && !m.halted && !hl;
    if (!rs) begin
      chk("taken", {31'd0, taken}, {31'd0, tk});
      chk("pc_plus", {16'd0, pc_plus}, {16'd0, pcp});
    end
    nx = m;
    if (rs) nx = '{pc: 16'h0, flags: 3'b0, halted: 1'b0};
    else if (!m.halted && !st) begin
      nx.flags = f_new;
      if (hl)      nx.halted = 1'b1;
      else if (tk) nx.pc     = tgt;
      else         nx.pc     = pcp;
    end
    q_exp.push_back(nx);
  endtask

  task automatic edge_pop();
    st_t e;
    @(posedge clk);
    #1;
    e = q_exp.pop_front();
    chk("pc", {16'd0, pc}, {16'd0, e.pc});
    chk("flags", {29'd0, flags}, {29'd0, e.flags});
    chk("halted", {31'd0, halted}, {31'd0, e.halted});
    m = e;
    @(negedge clk);
  endtask

  task automatic free_cyc();
    drive(0, 0, 0, 0, 0, 3'd0, 9'd0, 16'd0, 3'd0, 3'd0);
    edge_pop();
  endtask

  task automatic jump(input logic [15:0] a);
    drive(0, 0, 0, 1, 1, 3'd7, 9'd0, a, 3'd0, 3'd0);
    edge_pop();
  endtask

  task automatic set_flags(input logic [2:0] we, v);
    drive(0, 0, 0, 0, 0, 3'd0, 9'd0, 16'd0, we, v);
    edge_pop();
  endtask

  initial begin
    m = '{pc: 16'h1234, flags: 3'b111, halted: 1'b1};
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 3'd0, 9'd0, 16'd0, 3'd0, 3'd0);
    edge_pop();
    chk("rst_pc", {16'd0, pc}, 32'h0);
    chk("rst_flags", {29'd0, flags}, 32'h0);

    free_cyc(); chk("seq1", {16'd0, pc}, 32'h2);
    free_cyc(); chk("seq2", {16'd0, pc}, 32'h4);
    free_cyc(); chk("seq3", {16'd0, pc}, 32'h6);
    jump(16'hFFFE);
    free_cyc(); chk("wrap", {16'd0, pc}, 32'h0);

    jump(16'h0010);
    drive(0, 0, 0, 1, 0, 3'd7, 9'h1FE, 16'd0, 3'd0, 3'd0);
    chk("imm_neg_tk", {31'd0, taken}, 32'h1);
    edge_pop();
    chk("imm_neg", {16'd0, pc}, 32'h000E);
    jump(16'h0010);
    drive(0, 0, 0, 1, 0, 3'd7, 9'h0FF, 16'd0, 3'd0, 3'd0);
    edge_pop();
    chk("imm_pos", {16'd0, pc}, 32'h0210);

    set_flags(3'b010, 3'b010);
    drive(0, 0, 0, 1, 0, 3'd0, 9'd4, 16'd0, 3'd0, 3'd0);
    chk("ne_z1", {31'd0, taken}, 32'h0);
    edge_pop();
    drive(0, 0, 0, 1, 0, 3'd1, 9'd4, 16'd0, 3'd0, 3'd0);
    chk("eq_z1", {31'd0, taken}, 32'h1);
    edge_pop();
    set_flags(3'b011, 3'b001);
    drive(0, 0, 0, 1, 0, 3'd4, 9'd4, 16'd0, 3'd0, 3'd0);
    chk("ge_n1", {31'd0, taken}, 32'h0);
    edge_pop();
    drive(0, 0, 0, 1, 0, 3'd3, 9'd4, 16'd0, 3'd0, 3'd0);
    chk("lt_n1", {31'd0, taken}, 32'h1);
    edge_pop();
    set_flags(3'b100, 3'b100);
    drive(0, 0, 0, 1, 0, 3'd6, 9'd4, 16'd0, 3'd0, 3'd0);
    chk("ov_v1", {31'd0, taken}, 32'h1);
    edge_pop();

    set_flags(3'b111, 3'b000);
    drive(0, 0, 0, 1, 0, 3'd1, 9'd8, 16'd0, 3'b010, 3'b010);
    chk("byp_tk", {31'd0, taken}, 32'h1);
    chk("nobyp_tk", {31'd0, nb_taken}, 32'h0);
    edge_pop();
    chk("byp_flags", {29'd0, flags}, 32'h2);
    chk("nobyp_flags", {29'd0, nb_flags}, 32'h2);

    jump(16'h0040);
    drive(0, 1, 0, 1, 0, 3'd7, 9'd4, 16'd0, 3'b111, 3'b111);
    chk("stall_tk", {31'd0, taken}, 32'h0);
    edge_pop();
    chk("stall_pc", {16'd0, pc}, 32'h0040);
    chk("stall_flags", {29'd0, flags}, 32'h2);

    jump(16'h0020);
    drive(0, 0, 1, 0, 0, 3'd0, 9'd0, 16'd0, 3'b001, 3'b001);
    edge_pop();
    chk("halt_pc", {16'd0, pc}, 32'h0020);
    chk("halt_st", {31'd0, halted}, 32'h1);
    drive(0, 0, 0, 1, 1, 3'd7, 9'd0, 16'h0100, 3'b111, 3'b000);
    chk("halted_tk", {31'd0, taken}, 32'h0);
    edge_pop();
    chk("halted_pc", {16'd0, pc}, 32'h0020);
    drive(1, 1, 0, 0, 0, 3'd0, 9'd0, 16'd0, 3'd0, 3'd0);
    edge_pop();
    chk("rst_halt_pc", {16'd0, pc}, 32'h0);
    chk("rst_halt_st", {31'd0, halted}, 32'h0);
    chk("nb_rst_pc", {16'd0, nb_pc}, 32'h0);
    chk("nb_rst_halt", {31'd0, nb_halted}, 32'h0);
    chk("nb_pc_plus", {16'd0, nb_pc_plus}, 32'h2);
    free_cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
Parametrised program-counter unit for the single-cycle core. It holds the architectural PC and the N/Z/V flag register, and evaluates the 3-bit branch condition. It selects next-PC from sequential, PC-relative immediate or register-indirect target. It adds stall, sticky halt and optional same-cycle flag bypass, and replaces the purely combinational next-PC path in the fetch stage.

Parameters:
ADDR_W, 16, PC/address width in bits
IMM_W, 9, branch immediate width (two's complement)
PC_STEP, 2, byte increment per instruction
IMM_SHIFT, 1, left shift applied to sign-extended immediate
RESET_PC, 0, PC value loaded on reset
FLAG_BYPASS, 1, 1 = condition sees same-cycle flag writes; 0 = condition sees registered flags only

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hold PC and flags this cycle
halt  in  1  current instruction is HLT
br_en  in  1  current instruction is a branch
br_reg_mode  in  1  0 = target PC+STEP+(sext(imm)<<IMM_SHIFT); 1 = target br_reg
cond  in  3  condition code
imm  in  IMM_W  branch offset
br_reg  in  ADDR_W  register-indirect target
flag_we  in  3  per-flag write enable, bit0 N, bit1 Z, bit2 V
flag_in  in  3  new flag values, same bit order
pc  out  ADDR_W  current PC (registered)
pc_plus  out  ADDR_W  pc+PC_STEP (combinational, link value)
taken  out  1  branch taken this cycle (combinational)
flags  out  3  registered {V,Z,N}
halted  out  1  sticky halt status (registered)

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, flags=3'b000, halted=0. Reset wins over all other inputs, including mid-stall and while halted.
- Condition true table, with N/Z/V the effective flags:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z&!N
  - 011 LT: N
  - 100 GE: Z|!N
  - 101 LE: N|Z
  - 110 OV: V
  - 111: always
- Effective flags:
  - FLAG_BYPASS=1: per bit, flag_we[i] ? flag_in[i] : flags[i].
  - FLAG_BYPASS=0: flags.
- taken = br_en & cond_true & !stall & !halted & !halt.
- Next-state priority per edge: rst > halted > stall > halt > branch > sequential.
  - halted=1: pc, flags, halted hold; all inputs except rst ignored.
  - stall=1: pc and flags hold; flag_we and halt ignored this cycle.
  - halt=1: pc holds (stays at HLT address); halted<=1 next cycle; flag_we still applied.
  - taken: pc <= target.
  - otherwise: pc <= pc_plus.
- Flag update (not stalled, not halted): flags[i] <= flag_in[i] where flag_we[i]=1; other bits hold.
- Arithmetic:
  - imm sign-extended to ADDR_W, then shifted left IMM_SHIFT; shifted-out bits dropped.
  - All additions are modulo 2^ADDR_W; no overflow flag, wrap is legal (0xFFFE+2=0x0000).
  - Immediate target base is pc_plus, not pc.
- Latency: next-PC visible on pc one cycle after the deciding edge; taken and pc_plus combinational, zero latency.
- br_reg_mode is ignored when br_en=0.

Decomposition:
- Package pc_ctrl_pkg:
  - condition-code localparams COND_NE..COND_UNCOND
  - flag index constants FLAG_N=0, FLAG_Z=1, FLAG_V=2
- Sub-module branch_cond_eval: combinational (cond, N, Z, V) -> cond_true, instantiated once.
- Adders inferred with +; no adder instance required.

Test Plan:
1. Reset -> pc=0x0000, flags=000, halted=0; three free cycles -> pc 0x0002, 0x0004, 0x0006; then wrap: from pc=0xFFFE, one free cycle -> pc=0x0000.
2. pc=0x0010, br_en=1, cond=111, imm=9'h1FE -> taken=1, next pc=0x0012+0xFFFC=0x000E; imm=9'h0FF -> pc=0x0012+0x01FE=0x0210.
3. flags Z=1, cond=000 -> taken=0, pc+2; cond=001 -> taken; cond=100 with N=1,Z=0 -> not taken; cond=110 with V=1 -> taken.
4. Bypass: flags=000, flag_we=010, flag_in=010, cond=001 same cycle -> taken=1 (FLAG_BYPASS=1), taken=0 with FLAG_BYPASS=0; flags=010 after edge either way.
5. pc=0x0040, stall=1 with br_en=1, cond=111, flag_we=111, flag_in=111 -> taken=0, pc stays 0x0040, flags unchanged.
6. pc=0x0020, halt=1 -> pc stays 0x0020, halted=1 next cycle; later br_en=1, cond=111 -> pc stays 0x0020; rst=1 -> pc=0x0000, halted=0.
